// File: rtl/dma_6502.sv
// Single-channel memory-to-memory DMA for the 6502 bus: stalls the CPU via RDY,
// copies LEN bytes from SRC to DST, then returns the bus and flags DONE/IRQ.
module dma_6502 #(
  parameter int unsigned                    address_width = 16,
  parameter int unsigned                    data_width    = 8,
  parameter logic [address_width-1:0]       BaseAddress   = 16'h9400
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [address_width-1:0] cpu_address_i,
  input  logic [data_width-1:0]    cpu_data_i,
  input  logic                     cpu_we_i,
  input  logic [data_width-1:0]    bus_data_i,
  output logic [address_width-1:0] bus_address_o,
  output logic [data_width-1:0]    bus_data_o,
  output logic                     bus_we_o,
  output logic [data_width-1:0]    data_o,
  output logic                     cpu_rdy_o,
  output logic                     irq_o
);

  localparam int unsigned AW = address_width;
  localparam int unsigned DW = data_width;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_RESTORE
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   src_q, src_d, dst_q, dst_d, len_q, len_d;
  logic [AW-1:0]   src_cnt_q, src_cnt_d, dst_cnt_q, dst_cnt_d, len_cnt_q, len_cnt_d;
  logic            irq_en_q, irq_en_d, src_fixed_q, src_fixed_d, dst_fixed_q, dst_fixed_d;
  logic            done_q, done_d, rdy_q, rdy_d;
  logic [DW-1:0]   data_q, data_d;

  logic            in_win;
  logic [2:0]      offset;
  logic            reg_wr;

  assign in_win = (cpu_address_i[AW-1:3] == BaseAddress[AW-1:3]);
  assign offset = cpu_address_i[2:0];
  assign reg_wr = (state_q == S_IDLE) && cpu_we_i && in_win;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      src_cnt_q   <= '0;
      dst_cnt_q   <= '0;
      len_cnt_q   <= '0;
      irq_en_q    <= 1'b0;
      src_fixed_q <= 1'b0;
      dst_fixed_q <= 1'b0;
      done_q      <= 1'b0;
      rdy_q       <= 1'b1;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      len_q       <= len_d;
      src_cnt_q   <= src_cnt_d;
      dst_cnt_q   <= dst_cnt_d;
      len_cnt_q   <= len_cnt_d;
      irq_en_q    <= irq_en_d;
      src_fixed_q <= src_fixed_d;
      dst_fixed_q <= dst_fixed_d;
      done_q      <= done_d;
      rdy_q       <= rdy_d;
      data_q      <= data_d;
    end
  end

  // Next state, register writes and the bus mux.
  always_comb begin
    state_d       = state_q;
    src_d         = src_q;
    dst_d         = dst_q;
    len_d         = len_q;
    src_cnt_d     = src_cnt_q;
    dst_cnt_d     = dst_cnt_q;
    len_cnt_d     = len_cnt_q;
    irq_en_d      = irq_en_q;
    src_fixed_d   = src_fixed_q;
    dst_fixed_d   = dst_fixed_q;
    done_d        = done_q;
    rdy_d         = rdy_q;
    bus_address_o = cpu_address_i;
    bus_data_o    = cpu_data_i;
    bus_we_o      = cpu_we_i;

    unique case (state_q)
      S_IDLE: begin
        if (reg_wr) begin
          unique case (offset)
            3'd0: src_d[7:0]  = cpu_data_i;
            3'd1: src_d[15:8] = cpu_data_i;
            3'd2: dst_d[7:0]  = cpu_data_i;
            3'd3: dst_d[15:8] = cpu_data_i;
            3'd4: len_d[7:0]  = cpu_data_i;
            3'd5: len_d[15:8] = cpu_data_i;
            3'd6: begin
              irq_en_d    = cpu_data_i[1];
              src_fixed_d = cpu_data_i[2];
              dst_fixed_d = cpu_data_i[3];
              if (cpu_data_i[7]) done_d = 1'b0;
              if (cpu_data_i[0]) begin
                if (len_q != '0) begin
                  src_cnt_d = src_q;
                  dst_cnt_d = dst_q;
                  len_cnt_d = len_q;
                  rdy_d     = 1'b0;
                  state_d   = S_READ;
                end else begin
                  done_d = 1'b1;
                end
              end
            end
            default: ;
          endcase
        end
      end
      S_READ: begin
        bus_address_o = src_cnt_q;
        bus_data_o    = '0;
        bus_we_o      = 1'b0;
        state_d       = S_WRITE;
      end
      S_WRITE: begin
        bus_address_o = dst_cnt_q;
        bus_data_o    = bus_data_i;
        bus_we_o      = 1'b1;
        len_cnt_d     = len_cnt_q - AW'(1);
        if (!src_fixed_q) src_cnt_d = src_cnt_q + AW'(1);
        if (!dst_fixed_q) dst_cnt_d = dst_cnt_q + AW'(1);
        state_d = (len_cnt_q == AW'(1)) ? S_RESTORE : S_READ;
      end
      S_RESTORE: begin
        // Re-present the CPU's frozen address so its pending read data is correct.
        bus_address_o = cpu_address_i;
        bus_we_o      = 1'b0;
        rdy_d         = 1'b1;
        done_d        = 1'b1;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Register read data, one cycle behind the address like the peripherals.
  always_comb begin
    data_d = '0;
    if ((state_q == S_IDLE) && in_win) begin
      unique case (offset)
        3'd0: data_d = src_q[7:0];
        3'd1: data_d = src_q[15:8];
        3'd2: data_d = dst_q[7:0];
        3'd3: data_d = dst_q[15:8];
        3'd4: data_d = len_q[7:0];
        3'd5: data_d = len_q[15:8];
        3'd6: data_d = {4'b0000, dst_fixed_q, src_fixed_q, irq_en_q, 1'b0};
        3'd7: data_d = {6'b000000, done_q, (state_q != S_IDLE)};
        default: data_d = '0;
      endcase
    end
  end

  assign data_o    = data_q;
  assign cpu_rdy_o = rdy_q;
  assign irq_o     = done_q & irq_en_q;

endmodule

// File: doc/dma_6502.md
# dma_6502

Single-channel memory-to-memory DMA controller for the 6502 system bus. It sits between the `cpu_65c02` core and the peripheral address/data mux. When started, it stalls the CPU through `RDY`, takes over the shared bus, and copies a block of bytes between any two mapped addresses (RAM, SPI/ADC data registers, UART). It then hands the bus back and optionally raises an interrupt.

## Interface
Parameters:
- `BaseAddress`, `'h9400`: base of the 8-byte register window.
- `address_width`, `16`: bus address width.
- `data_width`, `8`: bus data width.

Ports:
- `clk_i`, input, 1: system clock; the only clock.
- `reset_i`, input, 1: reset; synchronous, active-high.
- `cpu_address_i`, input, 16: CPU `AB`.
- `cpu_data_i`, input, 8: CPU `DO`.
- `cpu_we_i`, input, 1: CPU `WE`.
- `bus_data_i`, input, 8: muxed read data (`data_reg`), valid the cycle after its address.
- `bus_address_o`, output, 16: address to peripherals.
- `bus_data_o`, output, 8: write data to peripherals.
- `bus_we_o`, output, 1: write enable to peripherals.
- `data_o`, output, 8: register read data into the bus mux.
- `cpu_rdy_o`, output, 1: drives CPU `RDY`; registered.
- `irq_o`, output, 1: level interrupt. The top level ORs it with the existing `irq`.

## Operation
- Bus mux, combinational:
  - Granted (any non-IDLE state): `bus_*_o` carry the DMA values.
  - Otherwise: `cpu_address_i`, `cpu_data_i` and `cpu_we_i` pass through unchanged.
- Registers at offsets from `BaseAddress`. Decode uses `cpu_address_i`, in IDLE only.
  - 0/1 `SRC_L`/`SRC_H`, 2/3 `DST_L`/`DST_H`, 4/5 `LEN_L`/`LEN_H`: read/write.
  - 6 `CTRL`, write:
    - bit0 START, self-clearing.
    - bit1 IRQ_EN, stored.
    - bit2 SRC_FIXED, stored.
    - bit3 DST_FIXED, stored.
    - bit7 CLR_DONE, self-clearing.
  - 6 `CTRL`, read: the stored bits; bits 0 and 7 read as 0.
  - 7 `STATUS`, read-only: bit0 BUSY, bit1 DONE.
- `data_o` is registered from the previous cycle's address, matching peripheral one-cycle read latency. It is 0 when that address is outside the window.
- FSM states:
  - IDLE:
    - CPU write to CTRL with START=1 and LEN≠0: load working copies of SRC/DST/LEN, go to READ, `cpu_rdy_o`←0.
    - START=1 with LEN=0: no grant, DONE←1 next cycle.
  - READ: `bus_address_o`=src_cnt, `bus_we_o`=0. Go to WRITE.
  - WRITE: `bus_address_o`=dst_cnt, `bus_data_o`=`bus_data_i`, `bus_we_o`=1.
    - len_cnt−1.
    - src_cnt+1 unless SRC_FIXED; dst_cnt+1 unless DST_FIXED.
    - len_cnt after decrement ≠0: go to READ. =0: go to RESTORE.
  - RESTORE: bus shows `cpu_address_i` with `bus_we_o`=0, so the registered read data matches the CPU's frozen address.
    - `cpu_rdy_o`←1, DONE←1, go to IDLE.
- Arithmetic:
  - Address counters are 16-bit and wrap `'hFFFF`→`'h0000`.
  - Programmed SRC/DST/LEN registers are not modified; working counters are internal.
- CPU `cpu_we_i` is ignored while granted; the Arlet core may assert `WE` while stalled.
- Simultaneous START and CLR_DONE: DONE clears, then the transfer starts.
- DONE stays set until CLR_DONE or reset. `irq_o` = DONE & IRQ_EN.
- Reset (any state, including mid-transfer):
  - FSM→IDLE; all registers and counters 0.
  - `cpu_rdy_o`=1, `irq_o`=0, `data_o`=0.
  - Bus passes through the CPU.

## Timing
- START write in cycle T:
  - T+1: READ of byte 0, `cpu_rdy_o`=0.
  - T+2: WRITE of byte 0.
  - Byte k: READ at T+1+2k, WRITE at T+2+2k.
- For N bytes:
  - RESTORE at T+2N+1.
  - IDLE with `cpu_rdy_o`=1 at T+2N+2.
  - DONE and `irq_o` visible at T+2N+2.
  - Stall length is exactly 2N+1 cycles.
- LEN=0: DONE=1 at T+1; `cpu_rdy_o` never drops.
- CLR_DONE written at T: DONE=0 and `irq_o`=0 at T+1.
- The maximum transfer is 65535 bytes; LEN=`'hFFFF` stalls the CPU for 131071 cycles.

## Test plan
- Block copy:
  - Stimulus: RAM `'h0300`..`'h0303`=11,22,33,44; SRC=`'h0300`, DST=`'h0400`, LEN=4; START.
  - Response: `cpu_rdy_o` low for 9 cycles; `'h0400`..`'h0403`=11,22,33,44; STATUS=`'h02`; the CPU's next instruction fetch reads the correct opcode.
- Zero length:
  - Stimulus: LEN=0, START with IRQ_EN.
  - Response: DONE=1 and `irq_o`=1 at T+1; `bus_we_o` never driven by the DMA; `cpu_rdy_o` stays 1.
- Fixed source:
  - Stimulus: SRC_FIXED, SRC=`'h0500` holding `'hA5`, DST=`'h0600`, LEN=3.
  - Response: `bus_address_o` shows `'h0500` on all 3 READs; `'h0600`..`'h0602`=`'hA5`.
- Wrap-around:
  - Stimulus: DST=`'hFFFF`, LEN=2.
  - Response: the second WRITE goes to address `'h0000`.
  - Stimulus: read back SRC/DST/LEN afterwards.
  - Response: they hold their original values.
- Reset mid-transfer:
  - Stimulus: LEN=8, assert `reset_i` at T+5 for one cycle.
  - Response: next cycle `cpu_rdy_o`=1, bus equals the CPU inputs, STATUS=0, SRC/DST/LEN read 0, no further DMA writes.
- IRQ clear:
  - Stimulus: after the copy completes with IRQ_EN set, `irq_o`=1; write CTRL=`'h82`.
  - Response: `irq_o`=0 and DONE=0 next cycle; IRQ_EN reads back 1.
